updown_cnt_ctrl: RTL and testbench

Sweep controller for the 4-bit up/down counter. It owns the counter's `mode` and `rst` inputs and watches its `out` value. On command it drives the counter to a programmed low bound, then ping-pongs it between low and high bounds for a programmed number of sweeps, and parks it in reset when the sweeps finish. It sits between the control logic and the counter instance, and all counter sequencing goes through it.

---
 rtl/updown_cnt_ctrl_if.sv | 26 ++
 rtl/updown_cnt_ctrl.sv | 142 ++++++++++++++
 tb/tb_updown_cnt_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_cnt_ctrl_if.sv
// Control/status bundle between the sweep controller, its host logic and the
// 4-bit up/down counter it sequences.
interface updown_cnt_ctrl_if;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] sweeps;
  logic [3:0] cnt_val;
  logic       cnt_mode;
  logic       cnt_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweep_cnt;

  modport master (
    output start, stop, lo, hi, sweeps, cnt_val,
    input  cnt_mode, cnt_rst, busy, done, err, sweep_cnt
  );

  modport slave (
    input  start, stop, lo, hi, sweeps, cnt_val,
    output cnt_mode, cnt_rst, busy, done, err, sweep_cnt
  );
endinterface

// File: rtl/updown_cnt_ctrl.sv
// Sweep controller: seeks the counter to lo, ping-pongs it between lo and hi
// for the programmed number of sweeps, then parks it in reset.
module updown_cnt_ctrl (
  input  logic               clk,
  input  logic               rst,
  updown_cnt_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    UP,
    DOWN,
    FINISH
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] sweeps_q, sweeps_d;
  logic       cnt_mode_q, cnt_mode_d;
  logic       cnt_rst_q, cnt_rst_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] sweep_cnt_q, sweep_cnt_d;

  logic [3:0] hi_m1;
  logic [3:0] lo_p1;
  logic [3:0] sweep_inc;

  // Direction flips one count early because the counter steps on the same
  // edge that the new mode is registered.
  assign hi_m1     = hi_q - 4'd1;
  assign lo_p1     = lo_q + 4'd1;
  assign sweep_inc = sweep_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    cnt_mode_d  = cnt_mode_q;
    cnt_rst_d   = cnt_rst_q;
    busy_d      = busy_q;
    sweep_cnt_d = sweep_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (state_q != IDLE && bus.stop) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      cnt_rst_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_rst_d = 1'b0;
          if (bus.start && !bus.stop) begin
            if (bus.lo >= bus.hi || bus.sweeps == 4'd0) begin
              err_d = 1'b1;
            end else begin
              lo_d        = bus.lo;
              hi_d        = bus.hi;
              sweeps_d    = bus.sweeps;
              cnt_rst_d   = 1'b1;
              cnt_mode_d  = 1'b1;
              busy_d      = 1'b1;
              sweep_cnt_d = '0;
              state_d     = SEEK;
            end
          end
        end
        SEEK: begin
          if (bus.cnt_val == hi_m1) begin
            cnt_mode_d = 1'b0;
            state_d    = DOWN;
          end else if (bus.cnt_val == lo_q) begin
            state_d = UP;
          end
        end
        UP: begin
          if (bus.cnt_val == hi_m1) begin
            cnt_mode_d = 1'b0;
            state_d    = DOWN;
          end
        end
        DOWN: begin
          if (bus.cnt_val == lo_p1) begin
            cnt_mode_d  = 1'b1;
            sweep_cnt_d = sweep_inc;
            state_d     = (sweep_inc == sweeps_q) ? FINISH : UP;
          end
        end
        FINISH: begin
          cnt_rst_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
        default: begin
          cnt_rst_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      cnt_mode_q  <= 1'b1;
      cnt_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sweeps_q    <= sweeps_d;
      cnt_mode_q  <= cnt_mode_d;
      cnt_rst_q   <= cnt_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign bus.cnt_mode  = cnt_mode_q;
  assign bus.cnt_rst   = cnt_rst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// Bench for updown_cnt_ctrl: a 4-bit counter model closes the loop, and a
// position-based sweep model predicts every output cycle by cycle.
module tb_updown_cnt_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  updown_cnt_ctrl_if ifc ();

  updown_cnt_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Counter being controlled: async clear through cnt_rst, steps every clock.
  logic [3:0] cnt_q = 4'd0;
  always @(posedge clk or negedge ifc.cnt_rst) begin
    if (!ifc.cnt_rst) cnt_q <= 4'd0;
    else              cnt_q <= ifc.cnt_mode ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end
  assign ifc.cnt_val = cnt_q;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a position p counted from the first busy cycle.
  bit m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int m_p = 0, m_lo = 0, m_hi = 1, m_s = 0, m_len = 0, m_sw = 0;

  function automatic int exp_val(input int p);
    int per, r;
    if (p <= m_lo) return p;
    per = 2 * (m_hi - m_lo);
    r   = (p - m_lo) % per;
    return m_lo + ((r <= m_hi - m_lo) ? r : per - r);
  endfunction

  function automatic int exp_sw(input int p);
    if (p < m_lo) return 0;
    return (p - m_lo) / (2 * (m_hi - m_lo));
  endfunction

  function automatic int exp_mode(input int p);
    if (p < m_lo) return 1;
    return (((p - m_lo) % (2 * (m_hi - m_lo))) < (m_hi - m_lo)) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_sw   <= 0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (m_busy) begin
        if (ifc.stop) begin
          m_sw   <= exp_sw(m_p);
          m_busy <= 1'b0;
        end else if (m_p == m_len - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_sw   <= m_s;
        end else begin
          m_p <= m_p + 1;
        end
      end else if (ifc.start && !ifc.stop) begin
        if (ifc.lo >= ifc.hi || ifc.sweeps == 4'd0) begin
          m_err <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          m_p    <= 0;
          m_lo   <= int'(ifc.lo);
          m_hi   <= int'(ifc.hi);
          m_s    <= int'(ifc.sweeps);
          m_len  <= int'(ifc.lo) + 2 * int'(ifc.sweeps) * (int'(ifc.hi) - int'(ifc.lo)) + 1;
          m_sw   <= 0;
        end
      end
    end
  end

  int cap_q[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("busy",    ifc.busy,    m_busy);
      chk("cnt_rst", ifc.cnt_rst, m_busy);
      chk("done",    ifc.done,    m_done);
      chk("err",     ifc.err,     m_err);
      if (m_busy) begin
        chk("cnt_val",   ifc.cnt_val,   exp_val(m_p));
        chk("sweep_cnt", ifc.sweep_cnt, exp_sw(m_p));
        chk("cnt_mode",  ifc.cnt_mode,  exp_mode(m_p));
      end else begin
        chk("cnt_val_idle",   ifc.cnt_val,   0);
        chk("sweep_cnt_idle", ifc.sweep_cnt, m_sw);
      end
      if (ifc.busy) cap_q.push_back(int'(ifc.cnt_val));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input int lo, input int hi, input int s);
    ifc.lo     = 4'(lo);
    ifc.hi     = 4'(hi);
    ifc.sweeps = 4'(s);
    ifc.start  = 1'b1;
    cap_q.delete();
    step();
    ifc.start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int k = 0; k < 700; k++) begin
      step();
      if (ifc.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_done_timeout", got, 1);
  endtask

  int seq_a[15] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
  int seq_c[10] = '{0, 1, 2, 3, 4, 3, 4, 3, 4, 3};

  initial begin
    ifc.start  = 1'b0;
    ifc.stop   = 1'b0;
    ifc.lo     = '0;
    ifc.hi     = '0;
    ifc.sweeps = '0;
    repeat (3) step();
    chk("rst_cnt_rst",   ifc.cnt_rst,   0);
    chk("rst_cnt_mode",  ifc.cnt_mode,  1);
    chk("rst_busy",      ifc.busy,      0);
    chk("rst_done",      ifc.done,      0);
    chk("rst_err",       ifc.err,       0);
    chk("rst_sweep_cnt", ifc.sweep_cnt, 0);
    rst = 1'b1;
    repeat (2) step();

    // lo=2 hi=5 sweeps=2
    start_run(2, 5, 2);
    wait_done();
    chk("a_busy_len", cap_q.size(), 15);
    for (int i = 0; i < 15 && i < cap_q.size(); i++) chk("a_seq", cap_q[i], seq_a[i]);
    chk("a_sweep_cnt", ifc.sweep_cnt, 2);
    chk("a_cnt_rst",   ifc.cnt_rst,   0);
    step();
    chk("a_done_pulse", ifc.done, 0);

    // Full range, no wrap
    start_run(0, 15, 1);
    wait_done();
    chk("b_busy_len", cap_q.size(), 31);
    if (cap_q.size() == 31) begin
      chk("b_peak", cap_q[15], 15);
      chk("b_last", cap_q[30], 0);
    end

    // Seek turns straight into DOWN
    start_run(3, 4, 3);
    wait_done();
    chk("c_busy_len", cap_q.size(), 10);
    for (int i = 0; i < 10 && i < cap_q.size(); i++) chk("c_seq", cap_q[i], seq_c[i]);
    chk("c_sweep_cnt", ifc.sweep_cnt, 3);

    // Rejected starts
    start_run(5, 5, 2);
    chk("rej_eq_err",  ifc.err,     1);
    chk("rej_eq_busy", ifc.busy,    0);
    chk("rej_eq_cnt",  ifc.cnt_val, 0);
    step();
    chk("rej_eq_err_pulse", ifc.err, 0);
    start_run(2, 9, 0);
    chk("rej_s0_err",  ifc.err,  1);
    chk("rej_s0_busy", ifc.busy, 0);
    step();

    // Stop while counting down through 4 in the second sweep
    start_run(2, 6, 3);
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (ifc.busy && !ifc.cnt_mode && ifc.cnt_val == 4'd4 && ifc.sweep_cnt == 4'd1) begin
          hit = 1'b1;
          break;
        end
        step();
      end
      chk("stop_reach_timeout", hit, 1);
    end
    ifc.stop = 1'b1;
    step();
    ifc.stop = 1'b0;
    chk("stop_busy",      ifc.busy,      0);
    chk("stop_cnt_rst",   ifc.cnt_rst,   0);
    chk("stop_done",      ifc.done,      0);
    chk("stop_sweep_cnt", ifc.sweep_cnt, 1);
    repeat (2) step();

    // start together with stop in IDLE
    ifc.stop = 1'b1;
    start_run(1, 7, 1);
    ifc.stop = 1'b0;
    chk("ss_busy", ifc.busy, 0);
    chk("ss_err",  ifc.err,  0);
    step();

    // Async reset mid-UP
    start_run(1, 9, 2);
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (ifc.busy && ifc.cnt_mode && ifc.cnt_val == 4'd5) begin
          hit = 1'b1;
          break;
        end
        step();
      end
      chk("rst_reach_timeout", hit, 1);
    end
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_cnt_rst",   ifc.cnt_rst,   0);
    chk("mid_rst_cnt_mode",  ifc.cnt_mode,  1);
    chk("mid_rst_busy",      ifc.busy,      0);
    chk("mid_rst_done",      ifc.done,      0);
    chk("mid_rst_err",       ifc.err,       0);
    chk("mid_rst_sweep_cnt", ifc.sweep_cnt, 0);
    chk("mid_rst_cnt_val",   ifc.cnt_val,   0);
    repeat (2) step();
    rst = 1'b1;
    step();

    // Randomized traffic, including starts while busy and bound changes mid-run
    for (int i = 0; i < 4000; i++) begin
      ifc.start  = ($urandom_range(0, 15) == 0);
      ifc.stop   = ($urandom_range(0, 99) == 0);
      ifc.lo     = 4'($urandom);
      ifc.hi     = 4'($urandom);
      ifc.sweeps = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      step();
    end
    ifc.start = 1'b0;
    ifc.stop  = 1'b1;
    repeat (3) step();
    ifc.stop = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
